// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver with mid-bit sampling.
// Frames are start(0) + DATA_BITS data bits (LSB first) + stop(1). Each
// received byte goes into a valid/ready holding register. The receiver flags
// framing errors and overruns with one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// between the data and the stop bit.
module uart_rx_frame #(
  parameter int OS_DIV    = 326,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_W = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  logic                 rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]     div_q;
  logic                 os_tick;
  logic [2:0]           state_q, state_d;
  logic [3:0]           smp_q, smp_d;
  logic [BIT_W-1:0]     bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign par_bad = ^{shreg_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample divider. It ticks once every OS_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              div_q <= '0;
    else if (div_q == DIV_W'(OS_DIV - 1))    div_q <= '0;
    else                                     div_q <= div_q + 1'b1;
  end

  assign os_tick = (div_q == DIV_W'(OS_DIV - 1));

  // Frame FSM. It advances only on oversample ticks. START waits 8 ticks so it
  // lands mid start bit, and later bits are sampled every 16 ticks after that.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    fe_d    = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (os_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            smp_d   = 4'd0;
          end
        end
        ST_START: begin
          if (smp_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              smp_d   = 4'd0;
              bitn_d  = '0;
            end else begin
              state_d = ST_IDLE;   // runt low pulse: ignore silently
            end
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (smp_q == 4'd15) begin
            smp_d   = 4'd0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bitn_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bitn_d = bitn_q + 1'b1;
            end
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (smp_q == 4'd15) begin
            smp_d   = 4'd0;
            par_d   = rx_s_q;
            state_d = ST_STOP;
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
`endif
        ST_STOP: begin
          if (smp_q == 4'd15) begin
            smp_d = 4'd0;
            if (!rx_s_q) begin
              fe_d    = 1'b1;      // a held-low line (break) gives one error, then waits
              state_d = ST_WAIT;
            end else if (par_bad) begin
              fe_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              deliver = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
        ST_WAIT: begin
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Holding register. A delivery on the same cycle as a consume keeps
  // rx_valid high and is not an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ready;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      smp_q   <= 4'd0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame (OS_DIV=4, DATA_BITS=8, 64 clk per bit).
// A behavioural model tracks the holding register. Each frame's delivery or
// error is expected within a short window around the stop-bit sample time.
module tb_uart_rx_frame;
  localparam int DB     = 8;
  localparam int BITCLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB       = DB + 2 + PAR;
  // Stop sample is 8 ticks (start check) plus 16 ticks per later bit, 4 clk/tick.
  localparam int STOP_CLK = 4 * (8 + 16 * (NB - 1));
  localparam int WLO      = STOP_CLK;
  localparam int WHI      = STOP_CLK + 15;

  logic          clk = 1'b0;
  logic          rst_n, rx, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_frame #(.OS_DIV(4), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  int fe_seen = 0, ov_seen = 0;
  bit in_win = 1'b0;
  bit ev_deliver = 1'b0, ev_rdy = 1'b0;
  logic [7:0] ev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model of the holding register plus per-window event accounting.
  initial begin
    logic [7:0] m_data;
    bit m_valid, prev_win;
    int fe_w, ov_w, exp_fe, exp_ov;
    m_data = '0; m_valid = 0; prev_win = 0; fe_w = 0; ov_w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        m_data = '0; m_valid = 0; prev_win = 0; fe_w = 0; ov_w = 0;
      end else begin
        if (frame_err) fe_seen++;
        if (overrun)   ov_seen++;
        if (in_win) begin
          if (frame_err) fe_w++;
          if (overrun)   ov_w++;
        end else begin
          if (prev_win) begin
            exp_fe = ev_deliver ? 0 : 1;
            exp_ov = (ev_deliver && !ev_rdy && m_valid) ? 1 : 0;
            if (ev_deliver) begin
              m_data  = ev_data;
              m_valid = !ev_rdy;       // ready held high consumes it right away
            end else if (ev_rdy) begin
              m_valid = 0;
            end
            chk("window_frame_err_count", fe_w, exp_fe);
            chk("window_overrun_count", ov_w, exp_ov);
            fe_w = 0; ov_w = 0;
          end
          chk("rx_valid", rx_valid, m_valid);
          chk("rx_data", rx_data, m_data);
          chk("frame_err_outside_window", frame_err, 0);
          chk("overrun_outside_window", overrun, 0);
          if (m_valid && rx_ready) m_valid = 0;
        end
        prev_win = in_win;
      end
    end
  end

  // Drive one frame bit by bit. Set abort_at to stop part-way (-1 for a full frame).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input bit rnd_rdy, input bit win_rdy, input int abort_at);
    logic [NB-1:0] fb;
    fb = '0;
    for (int i = 0; i < DB; i++) fb[1+i] = d[i];
    if (PAR != 0) fb[DB+1] = (^d) ^ ~par_ok;
    fb[NB-1]   = stop_ok;
    ev_deliver = stop_ok && (par_ok || PAR == 0);
    ev_data    = d;
    ev_rdy     = win_rdy;
    for (int j = 0; j < NB * BITCLK; j++) begin
      if (j == abort_at) return;
      @(posedge clk); #1;
      rx       = fb[j / BITCLK];
      in_win   = (j >= WLO && j <= WHI);
      rx_ready = in_win ? win_rdy : (rnd_rdy ? 1'($urandom) : 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      rx = 1'b1; in_win = 1'b0;
      rx_ready = rnd_rdy ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic hold_low(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      rx = 1'b0; in_win = 1'b0; rx_ready = 1'b0;
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1; rx_ready = 1'b1;
    @(posedge clk); #1; rx_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0;
    logic [7:0] d;
    bit sok, pok;
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20, 0);

    // 1: basic byte, held until consumed
    send_frame(8'hA5, 1, 1, 0, 0, -1);
    idle(10, 0);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_no_frame_err", fe_seen, 0);
    pulse_ready();
    chk("t1_valid_drops", rx_valid, 0);
    chk("t1_data_holds", rx_data, 8'hA5);

    // 2: runt start pulse
    fe0 = fe_seen;
    hold_low(16);
    for (int j = 16; j < BITCLK; j++) begin
      idle(1, 0);
      if (j == 20) chk("t2_busy_during_runt", busy, 1);
    end
    chk("t2_busy_dropped", busy, 0);
    idle(64, 0);
    chk("t2_no_valid", rx_valid, 0);
    chk("t2_no_frame_err", fe_seen - fe0, 0);

    // 3: bad stop, then break; then a good frame
    fe0 = fe_seen;
    send_frame(8'h3C, 0, 1, 0, 0, -1);
    hold_low(5 * BITCLK);
    idle(128, 0);
    chk("t3_one_frame_err", fe_seen - fe0, 1);
    chk("t3_no_valid", rx_valid, 0);
    send_frame(8'h81, 1, 1, 0, 0, -1);
    idle(10, 0);
    chk("t3_data", rx_data, 8'h81);
    chk("t3_valid", rx_valid, 1);

    // 4: back-to-back overrun, then ready during delivery
    pulse_ready();
    ov0 = ov_seen;
    send_frame(8'h11, 1, 1, 0, 0, -1);
    send_frame(8'h22, 1, 1, 0, 0, -1);
    idle(10, 0);
    chk("t4_one_overrun", ov_seen - ov0, 1);
    chk("t4_data", rx_data, 8'h22);
    chk("t4_valid", rx_valid, 1);
    send_frame(8'h33, 1, 1, 0, 1, -1);
    idle(10, 0);
    chk("t4_no_overrun_with_ready", ov_seen - ov0, 1);
    chk("t4_data_ready", rx_data, 8'h33);

    // 5: reset in the middle of data bit 3
    send_frame(8'h5A, 1, 1, 0, 0, 4 * BITCLK + 32);
    chk("t5_busy_mid_frame", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; in_win = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_valid_in_reset", rx_valid, 0);
    chk("t5_data_in_reset", rx_data, 0);
    rst_n = 1'b1;
    idle(40, 0);
    chk("t5_valid_after_reset", rx_valid, 0);
    send_frame(8'hC3, 1, 1, 0, 0, -1);
    idle(10, 0);
    chk("t5_data", rx_data, 8'hC3);
    chk("t5_valid", rx_valid, 1);

`ifdef UART_RX_PARITY_EN
    // 6: parity good, then parity bad
    pulse_ready();
    send_frame(8'h07, 1, 1, 0, 0, -1);
    idle(10, 0);
    chk("t6_data", rx_data, 8'h07);
    chk("t6_valid", rx_valid, 1);
    pulse_ready();
    fe0 = fe_seen;
    send_frame(8'h07, 1, 0, 0, 0, -1);
    idle(10, 0);
    chk("t6_parity_err", fe_seen - fe0, 1);
    chk("t6_no_valid", rx_valid, 0);
`endif

    // Random frames with random consumer behaviour
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom);
      sok = ($urandom_range(0, 4) != 0);
      pok = (PAR == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send_frame(d, sok, pok, 1, 1'($urandom), -1);
      idle(sok ? $urandom_range(0, 40) : BITCLK + $urandom_range(0, 40), 1);
    end
    idle(20, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
